// File: rtl/alu_arb_pkg.sv
// Shared definitions for the arbitrated ALU: opcodes, FSM state encoding
// and grant identifiers. Imported by alu_core and alu_share_arbiter.
package alu_arb_pkg;

   // ALU opcodes carried on reqN_sel_i
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   // Sequencer states: accept in IDLE, compute in EXEC, present in RESP
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Requester identifiers used for grant and last-grant tracking
   localparam logic GNT_0 = 1'b0;
   localparam logic GNT_1 = 1'b1;

endpackage

// File: rtl/alu_core.sv
// Purely combinational WIDTH-bit ALU producing a WIDTH+1-bit result.
// ADD puts the carry in the MSB, SUB is a two's-complement difference whose
// MSB flags a borrow, AND/XOR are zero-extended.
module alu_core
   import alu_arb_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [1:0]       sel_i,
   output logic [WIDTH:0]   result_o
);

   // Select the operation; widening both operands first keeps carry/borrow
   always_comb begin
      result_o = '0;
      case (sel_i)
         OP_ADD:  result_o = {1'b0, a_i} + {1'b0, b_i};
         OP_SUB:  result_o = {1'b0, a_i} - {1'b0, b_i};
         OP_AND:  result_o = {1'b0, a_i & b_i};
         OP_XOR:  result_o = {1'b0, a_i ^ b_i};
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// One ALU shared between two valid/ready requesters. An op is accepted in
// IDLE, computed and registered in EXEC, and held in RESP until the granted
// requester consumes it, so each op takes at least three cycles.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration; without it
// requester 0 has fixed priority and no last-grant state exists.
module alu_share_arbiter
   import alu_arb_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [WIDTH-1:0] req0_a_i,
   input  logic [WIDTH-1:0] req0_b_i,
   input  logic [1:0]       req0_sel_i,
   output logic             rsp0_valid_o,
   input  logic             rsp0_ready_i,
   output logic [WIDTH:0]   rsp0_data_o,
   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [WIDTH-1:0] req1_a_i,
   input  logic [WIDTH-1:0] req1_b_i,
   input  logic [1:0]       req1_sel_i,
   output logic             rsp1_valid_o,
   input  logic             rsp1_ready_i,
   output logic [WIDTH:0]   rsp1_data_o,
   output logic             busy_o
);

   state_t             state_q, state_d;
   logic               gnt_q, gnt_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [1:0]         sel_q, sel_d;
   logic [WIDTH:0]     result_q, result_d;
   logic [WIDTH:0]     alu_result;
   logic               pick;
`ifdef ALU_ARB_RR_EN
   logic               last_grant_q, last_grant_d;
`endif

   alu_core #(.WIDTH(WIDTH)) u_alu_core (
      .a_i      (a_q),
      .b_i      (b_q),
      .sel_i    (sel_q),
      .result_o (alu_result)
   );

`ifdef ALU_ARB_RR_EN
   // Round-robin pick: on a tie the requester not granted last wins
   always_comb begin
      pick = GNT_0;
      if (req0_valid_i && req1_valid_i) begin
         pick = (last_grant_q == GNT_0) ? GNT_1 : GNT_0;
      end else if (req1_valid_i) begin
         pick = GNT_1;
      end
   end
`else
   // Fixed priority pick: requester 0 wins every tie
   always_comb begin
      pick = req0_valid_i ? GNT_0 : GNT_1;
   end
`endif

   // Sequencer next-state, operand capture and handshake outputs
   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      a_d          = a_q;
      b_d          = b_q;
      sel_d        = sel_q;
      result_d     = result_q;
      req0_ready_o = 1'b0;
      req1_ready_o = 1'b0;
`ifdef ALU_ARB_RR_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req0_valid_i || req1_valid_i) begin
               req0_ready_o = (pick == GNT_0);
               req1_ready_o = (pick == GNT_1);
               gnt_d        = pick;
               a_d          = (pick == GNT_0) ? req0_a_i   : req1_a_i;
               b_d          = (pick == GNT_0) ? req0_b_i   : req1_b_i;
               sel_d        = (pick == GNT_0) ? req0_sel_i : req1_sel_i;
`ifdef ALU_ARB_RR_EN
               last_grant_d = pick;
`endif
               state_d      = ST_EXEC;
            end
         end
         ST_EXEC: begin
            result_d = alu_result;
            state_d  = ST_RESP;
         end
         ST_RESP: begin
            if ((gnt_q == GNT_0 && rsp0_ready_i) || (gnt_q == GNT_1 && rsp1_ready_i)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q      <= ST_IDLE;
         gnt_q        <= GNT_0;
         a_q          <= '0;
         b_q          <= '0;
         sel_q        <= '0;
         result_q     <= '0;
`ifdef ALU_ARB_RR_EN
         last_grant_q <= GNT_1;
`endif
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         a_q          <= a_d;
         b_q          <= b_d;
         sel_q        <= sel_d;
         result_q     <= result_d;
`ifdef ALU_ARB_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   // Response channels: only the granted side sees valid data in RESP
   always_comb begin
      rsp0_valid_o = (state_q == ST_RESP) && (gnt_q == GNT_0);
      rsp1_valid_o = (state_q == ST_RESP) && (gnt_q == GNT_1);
      rsp0_data_o  = rsp0_valid_o ? result_q : '0;
      rsp1_data_o  = rsp1_valid_o ? result_q : '0;
      busy_o       = (state_q != ST_IDLE);
   end

endmodule
